// File: rtl/regfile_sequencer.sv
// Multi-cycle control FSM for the accumulator register file: accepts one
// instruction per handshake, drives the register-file strobes and runs data-memory loads.
module regfile_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [1:0]       instr_op_i,
    input  logic [2:0]       instr_reg_i,
    output logic             alu_en_o,
    output logic             cpyin_o,
    output logic             cpyout_o,
    output logic             mem_load_o,
    output logic [2:0]       reg_sel_o,
    output logic             mem_req_o,
    input  logic             mem_ack_i,
    output logic             done_o,
    output logic             timeout_err_o,
    output logic [CNT_W-1:0] instr_count_o
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] OP_ALU    = 2'b00;
    localparam logic [1:0] OP_CPYIN  = 2'b01;
    localparam logic [1:0] OP_CPYOUT = 2'b10;
    localparam logic [1:0] OP_LOAD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MEM_WAIT = 2'd2,
        WB       = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [2:0]        reg_sel_q, reg_sel_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              timeout_q, timeout_d;
    logic              alu_en_q, alu_en_d;
    logic              cpyin_q, cpyin_d;
    logic              cpyout_q, cpyout_d;
    logic              mem_load_q, mem_load_d;
    logic              mem_req_q, mem_req_d;
    logic              done_q, done_d;

    // Strobes are registered from the next state, so they are high exactly
    // while the FSM sits in EXEC / WB and stable across the negedge write.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        reg_sel_d  = reg_sel_q;
        timeout_d  = timeout_q;
        count_d    = count_q + CNT_W'(done_q);
        alu_en_d   = 1'b0;
        cpyin_d    = 1'b0;
        cpyout_d   = 1'b0;
        mem_load_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (instr_valid_i) begin
                    reg_sel_d = instr_reg_i;
                    wait_d    = '0;
                    if (instr_op_i == OP_LOAD) begin
                        state_d = MEM_WAIT;
                    end else begin
                        state_d  = EXEC;
                        alu_en_d = (instr_op_i == OP_ALU);
                        cpyin_d  = (instr_op_i == OP_CPYIN);
                        cpyout_d = (instr_op_i == OP_CPYOUT);
                        done_d   = 1'b1;
                    end
                end
            end
            EXEC: state_d = IDLE;
            MEM_WAIT: begin
                wait_d = wait_q + WAIT_W'(1);
                // An ack on the final wait cycle takes priority over the timeout.
                if (mem_ack_i) begin
                    state_d    = WB;
                    mem_load_d = 1'b1;
                    done_d     = 1'b1;
                end else if (TIMEOUT != 0 && wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            WB: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mem_req_d = (state_d == MEM_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            reg_sel_q  <= '0;
            count_q    <= '0;
            timeout_q  <= 1'b0;
            alu_en_q   <= 1'b0;
            cpyin_q    <= 1'b0;
            cpyout_q   <= 1'b0;
            mem_load_q <= 1'b0;
            mem_req_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            reg_sel_q  <= reg_sel_d;
            count_q    <= count_d;
            timeout_q  <= timeout_d;
            alu_en_q   <= alu_en_d;
            cpyin_q    <= cpyin_d;
            cpyout_q   <= cpyout_d;
            mem_load_q <= mem_load_d;
            mem_req_q  <= mem_req_d;
            done_q     <= done_d;
        end
    end

    assign instr_ready_o = (state_q == IDLE) && !reset;
    assign alu_en_o      = alu_en_q;
    assign cpyin_o       = cpyin_q;
    assign cpyout_o      = cpyout_q;
    assign mem_load_o    = mem_load_q;
    assign reg_sel_o     = reg_sel_q;
    assign mem_req_o     = mem_req_q;
    assign done_o        = done_q;
    assign timeout_err_o = timeout_q;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: hand-computed expectations for each
// op, load ack/timeout, reset mid-load and counter wrap (second instance, CNT_W=4).
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [1:0]  instr_op;
    logic [2:0]  instr_reg;
    logic        mem_ack;
    logic        instr_ready, alu_en, cpyin, cpyout, mem_load, mem_req, done, timeout_err;
    logic [2:0]  reg_sel;
    logic [15:0] instr_count;
    logic        ready4, alu4, cpyin4, cpyout4, load4, req4, done4, terr4;
    logic [2:0]  sel4;
    logic [3:0]  count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sequencer #(.TIMEOUT(16), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_op_i(instr_op), .instr_reg_i(instr_reg), .alu_en_o(alu_en), .cpyin_o(cpyin),
        .cpyout_o(cpyout), .mem_load_o(mem_load), .reg_sel_o(reg_sel), .mem_req_o(mem_req),
        .mem_ack_i(mem_ack), .done_o(done), .timeout_err_o(timeout_err),
        .instr_count_o(instr_count)
    );

    regfile_sequencer #(.TIMEOUT(16), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .instr_valid_i(instr_valid), .instr_ready_o(ready4),
        .instr_op_i(instr_op), .instr_reg_i(instr_reg), .alu_en_o(alu4), .cpyin_o(cpyin4),
        .cpyout_o(cpyout4), .mem_load_o(load4), .reg_sel_o(sel4), .mem_req_o(req4),
        .mem_ack_i(mem_ack), .done_o(done4), .timeout_err_o(terr4),
        .instr_count_o(count4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle; outputs are sampled 1ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_strobes(input string tag, input logic [3:0] exp_aclm,
                                 input logic exp_done);
        check({tag, "_strobes"}, {28'd0, alu_en, cpyin, cpyout, mem_load}, {28'd0, exp_aclm});
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] rg);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_reg   = rg;
        tick();
        instr_valid = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr_op = 2'b00; instr_reg = 3'd0; mem_ack = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_sel", {29'd0, reg_sel}, 32'd0);
        check("rst_count", {16'd0, instr_count}, 32'd0);
        check("rst_terr", {31'd0, timeout_err}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check_strobes("rst", 4'b0000, 1'b0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, instr_ready}, 32'd1);

        // Reset in the 2nd MEM_WAIT cycle, then a late ack.
        issue(2'b11, 3'd4);
        check("rl_req1", {31'd0, mem_req}, 32'd1);
        tick();
        check("rl_req2", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        mem_ack = 1'b1;
        tick();
        reset = 1'b0;
        check("rl_req_after", {31'd0, mem_req}, 32'd0);
        check_strobes("rl_after", 4'b0000, 1'b0);
        tick();
        check("rl_req_later", {31'd0, mem_req}, 32'd0);
        check_strobes("rl_later", 4'b0000, 1'b0);
        mem_ack = 1'b0;
        check("rl_count", {16'd0, instr_count}, 32'd0);
        check("rl_terr", {31'd0, timeout_err}, 32'd0);
        check("rl_ready", {31'd0, instr_ready}, 32'd1);

        // CPYIN r5.
        issue(2'b01, 3'd5);
        check_strobes("cpyin", 4'b0100, 1'b1);
        check("cpyin_sel", {29'd0, reg_sel}, 32'd5);
        check("cpyin_busy", {31'd0, instr_ready}, 32'd0);
        tick();
        check("cpyin_ready", {31'd0, instr_ready}, 32'd1);
        check("cpyin_count", {16'd0, instr_count}, 32'd1);
        check_strobes("cpyin_idle", 4'b0000, 1'b0);

        // Back-to-back ALU r2 then CPYOUT r3 with valid held high.
        instr_valid = 1'b1; instr_op = 2'b00; instr_reg = 3'd2;
        tick();
        instr_op = 2'b10; instr_reg = 3'd3;
        check_strobes("alu", 4'b1000, 1'b1);
        check("alu_sel", {29'd0, reg_sel}, 32'd2);
        tick();
        check_strobes("b2b_gap", 4'b0000, 1'b0);
        check("b2b_sel_hold", {29'd0, reg_sel}, 32'd2);
        check("b2b_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        check_strobes("cpyout", 4'b0010, 1'b1);
        check("cpyout_sel", {29'd0, reg_sel}, 32'd3);
        tick();
        check("b2b_count", {16'd0, instr_count}, 32'd3);
        check_strobes("b2b_idle", 4'b0000, 1'b0);

        // mem_ack in IDLE has no effect.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_strobes("idle_ack", 4'b0000, 1'b0);
        check("idle_ack_ready", {31'd0, instr_ready}, 32'd1);

        // LOAD r7, ack after 4 request cycles.
        issue(2'b11, 3'd7);
        for (int i = 0; i < 4; i++) begin
            check("ld_req", {31'd0, mem_req}, 32'd1);
            check_strobes("ld_wait", 4'b0000, 1'b0);
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check("ld_wb_req", {31'd0, mem_req}, 32'd0);
        check_strobes("ld_wb", 4'b0001, 1'b1);
        check("ld_sel", {29'd0, reg_sel}, 32'd7);
        tick();
        check_strobes("ld_idle", 4'b0000, 1'b0);
        check("ld_ready", {31'd0, instr_ready}, 32'd1);
        check("ld_count", {16'd0, instr_count}, 32'd4);

        // LOAD r1 with no ack: times out after 16 request cycles.
        issue(2'b11, 3'd1);
        n = 0;
        while (mem_req && n < 40) begin
            check("to_nodone", {31'd0, done}, 32'd0);
            tick();
            n++;
        end
        check("to_req_cycles", n, 32'd16);
        check("to_terr", {31'd0, timeout_err}, 32'd1);
        check("to_ready", {31'd0, instr_ready}, 32'd1);
        check_strobes("to_after", 4'b0000, 1'b0);
        check("to_count", {16'd0, instr_count}, 32'd4);
        issue(2'b01, 3'd6);
        check_strobes("to_cpyin", 4'b0100, 1'b1);
        tick();
        check("to_count2", {16'd0, instr_count}, 32'd5);

        // Ack on the 16th wait cycle wins over the timeout.
        issue(2'b11, 3'd2);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check_strobes("edge_wb", 4'b0001, 1'b1);
        check("edge_sel", {29'd0, reg_sel}, 32'd2);
        check("edge_terr_sticky", {31'd0, timeout_err}, 32'd1);
        tick();
        check("edge_count", {16'd0, instr_count}, 32'd6);

        // Counter wrap: 17 CPYINs from reset; CNT_W=4 instance wraps to 1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wrap_terr_clr", {31'd0, timeout_err}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            issue(2'b01, 3'(i));
            tick();
        end
        check("wrap_count16", {16'd0, instr_count}, 32'd17);
        check("wrap_count4", {28'd0, count4}, 32'd1);
        check("wrap_sel", {29'd0, reg_sel}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Strobes must never overlap.
    always @(negedge clk) begin
        if (32'(alu_en) + 32'(cpyin) + 32'(cpyout) + 32'(mem_load) > 1)
            check("strobe_overlap", {28'd0, alu_en, cpyin, cpyout, mem_load}, 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
